// File: rtl/error_angle_array.sv
// Array of independent signed error-angle counters. Each channel accumulates
// +1/-1 commands, can bleed itself back toward zero at reference-phase sample
// instants, and reports its sign as registered levels and one-cycle pulse gates.
module error_angle_array #(
    parameter int CHANNELS = 5,
    parameter int WIDTH    = 9
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ref_strobe,
    input  logic                        ao,
    input  logic                        del0,
    input  logic [CHANNELS-1:0]         inc_p,
    input  logic [CHANNELS-1:0]         inc_m,
    input  logic [CHANNELS-1:0]         clr,
    input  logic [CHANNELS-1:0]         drain,
    output logic [CHANNELS-1:0]         up_lvl,
    output logic [CHANNELS-1:0]         dn_lvl,
    output logic [CHANNELS-1:0]         pg_p,
    output logic [CHANNELS-1:0]         pg_m,
    output logic [CHANNELS*WIDTH-1:0]   err,
    output logic [CHANNELS-1:0]         sat
);

    // Two guard bits keep err + inc_p - inc_m + drain free of wraparound.
    localparam int EXT_W = WIDTH + 2;
    localparam logic signed [EXT_W-1:0] MAX_EXT = EXT_W'((1 << (WIDTH - 1)) - 1);
    localparam logic signed [EXT_W-1:0] MIN_EXT = -MAX_EXT;
    localparam logic signed [EXT_W-1:0] ONE     = EXT_W'(1);

    // True when the extended sum lies outside the symmetric counter range.
    function automatic logic over_range(input logic signed [EXT_W-1:0] v);
        return (v > MAX_EXT) || (v < MIN_EXT);
    endfunction

    // Symmetric clamp: the most-negative two's-complement code is never produced,
    // so the counter magnitude is identical in both directions.
    function automatic logic signed [WIDTH-1:0] sat_clamp(input logic signed [EXT_W-1:0] v);
        logic signed [EXT_W-1:0] c;
        if (v > MAX_EXT)
            c = MAX_EXT;
        else if (v < MIN_EXT)
            c = MIN_EXT;
        else
            c = v;
        return c[WIDTH-1:0];
    endfunction

    logic sample;
    logic pulse_en;

    // Shared sample qualification: a reference strobe only counts while the
    // analog output is enabled; del0 additionally gates pulses and draining.
    always_comb begin
        sample   = ref_strobe & ao;
        pulse_en = ref_strobe & ao & ~del0;
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic signed [WIDTH-1:0] err_q;
        logic                    sat_q;
        logic                    up_q;
        logic                    dn_q;
        logic                    pgp_q;
        logic                    pgm_q;
        logic                    err_pos;
        logic                    err_neg;
        logic signed [EXT_W-1:0] err_ext;
        logic signed [EXT_W-1:0] delta;
        logic signed [EXT_W-1:0] sum;

        // Sign decode of the pre-edge counter and the net step for this edge.
        always_comb begin
            err_neg = err_q[WIDTH-1];
            err_pos = !err_q[WIDTH-1] && (err_q != '0);
            err_ext = {{2{err_q[WIDTH-1]}}, err_q};
            delta   = '0;
            if (inc_p[i])
                delta = delta + ONE;
            if (inc_m[i])
                delta = delta - ONE;
            if (pulse_en && drain[i]) begin
                if (err_pos)
                    delta = delta - ONE;
                else if (err_neg)
                    delta = delta + ONE;
            end
            sum = err_ext + delta;
        end

        // Counter, sticky saturation flag, sign levels and pulse gates.
        always_ff @(posedge clk) begin
            if (rst) begin
                err_q <= '0;
                sat_q <= 1'b0;
                up_q  <= 1'b0;
                dn_q  <= 1'b0;
                pgp_q <= 1'b0;
                pgm_q <= 1'b0;
            end else begin
                if (clr[i]) begin
                    err_q <= '0;
                    sat_q <= 1'b0;
                end else begin
                    err_q <= sat_clamp(sum);
                    if (over_range(sum))
                        sat_q <= 1'b1;
                end

                if (!ao) begin
                    up_q <= 1'b0;
                    dn_q <= 1'b0;
                end else if (sample) begin
                    up_q <= err_pos;
                    dn_q <= err_neg;
                end

                pgp_q <= pulse_en & err_pos;
                pgm_q <= pulse_en & err_neg;
            end
        end

        assign err[i*WIDTH +: WIDTH] = err_q;
        assign sat[i]    = sat_q;
        assign up_lvl[i] = up_q;
        assign dn_lvl[i] = dn_q;
        assign pg_p[i]   = pgp_q;
        assign pg_m[i]   = pgm_q;
    end

endmodule

// File: tb/tb_error_angle_array.sv
// Scoreboard bench for error_angle_array: the stimulus process queues expected
// output values tagged with the cycle they must appear in; a monitor pops and
// compares them on the falling edge.
module tb_error_angle_array;

    localparam int CH = 5;
    localparam int W  = 9;

    logic            clk = 1'b0;
    logic            rst;
    logic            ref_strobe;
    logic            ao;
    logic            del0;
    logic [CH-1:0]   inc_p;
    logic [CH-1:0]   inc_m;
    logic [CH-1:0]   clr;
    logic [CH-1:0]   drain;
    logic [CH-1:0]   up_lvl;
    logic [CH-1:0]   dn_lvl;
    logic [CH-1:0]   pg_p;
    logic [CH-1:0]   pg_m;
    logic [CH*W-1:0] err;
    logic [CH-1:0]   sat;

    error_angle_array #(.CHANNELS(CH), .WIDTH(W)) dut (
        .clk(clk), .rst(rst), .ref_strobe(ref_strobe), .ao(ao), .del0(del0),
        .inc_p(inc_p), .inc_m(inc_m), .clr(clr), .drain(drain),
        .up_lvl(up_lvl), .dn_lvl(dn_lvl), .pg_p(pg_p), .pg_m(pg_m),
        .err(err), .sat(sat)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    localparam int F_ERR = 0, F_SAT = 1, F_UP = 2, F_DN = 3, F_PGP = 4, F_PGM = 5;

    typedef struct {
        int cyc;
        int ch;
        int f;
        int val;
    } exp_t;

    exp_t q[$];
    int   total  = 0;
    int   passed = 0;

    function automatic string fname(input int f);
        case (f)
            F_ERR:   return "err";
            F_SAT:   return "sat";
            F_UP:    return "up_lvl";
            F_DN:    return "dn_lvl";
            F_PGP:   return "pg_p";
            default: return "pg_m";
        endcase
    endfunction

    function automatic int actual(input int ch, input int f);
        logic signed [W-1:0] v;
        v = err[ch*W +: W];
        case (f)
            F_ERR:   return int'(v);
            F_SAT:   return int'(sat[ch]);
            F_UP:    return int'(up_lvl[ch]);
            F_DN:    return int'(dn_lvl[ch]);
            F_PGP:   return int'(pg_p[ch]);
            default: return int'(pg_m[ch]);
        endcase
    endfunction

    // Queue a value that must be visible after the coming rising edge.
    task automatic expect_next(input int ch, input int f, input int val);
        exp_t e;
        e.cyc = cyc + 1;
        e.ch  = ch;
        e.f   = f;
        e.val = val;
        q.push_back(e);
    endtask

    task automatic expect_all_zero();
        for (int c = 0; c < CH; c++)
            for (int f = 0; f < 6; f++)
                expect_next(c, f, 0);
    endtask

    // Advance one cycle, then drop all single-cycle commands.
    task automatic tick();
        @(negedge clk);
        inc_p      = '0;
        inc_m      = '0;
        clr        = '0;
        ref_strobe = 1'b0;
    endtask

    // Monitor: compare every queued expectation whose cycle has arrived.
    initial begin
        exp_t e;
        int   a;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                a = actual(e.ch, e.f);
                total++;
                if (a == e.val)
                    passed++;
                else
                    $display("FAIL %s ch%0d cycle %0d: got %0d, expected %0d",
                             fname(e.f), e.ch, e.cyc, a, e.val);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; ref_strobe = 1'b0; ao = 1'b1; del0 = 1'b0;
        inc_p = '0; inc_m = '0; clr = '0; drain = '0;
        @(negedge clk);

        // Reset with a coincident strobe clears everything.
        rst = 1'b1; ref_strobe = 1'b1; inc_p = '1;
        expect_all_zero();
        tick();
        rst = 1'b0;
        for (int c = 0; c < CH; c++) expect_next(c, F_PGP, 0);
        tick();

        // ch0: three increments, open-loop hold, then a sample.
        for (int k = 1; k <= 3; k++) begin
            inc_p = 5'b00001;
            expect_next(0, F_ERR, k);
            tick();
        end
        ref_strobe = 1'b1;
        expect_next(0, F_ERR, 3); expect_next(0, F_UP, 1);
        expect_next(0, F_DN, 0);  expect_next(0, F_PGP, 1);
        tick();
        expect_next(0, F_ERR, 3); expect_next(0, F_UP, 1); expect_next(0, F_PGP, 0);
        tick();

        // ch1: err=2, closed-loop drain over three consecutive samples.
        for (int k = 1; k <= 2; k++) begin
            inc_p = 5'b00010;
            tick();
        end
        drain[1] = 1'b1;
        ref_strobe = 1'b1;
        expect_next(1, F_ERR, 1); expect_next(1, F_PGP, 1); expect_next(1, F_UP, 1);
        tick();
        ref_strobe = 1'b1;
        expect_next(1, F_ERR, 0); expect_next(1, F_PGP, 1); expect_next(1, F_UP, 1);
        tick();
        ref_strobe = 1'b1;
        expect_next(1, F_ERR, 0); expect_next(1, F_PGP, 0);
        expect_next(1, F_UP, 0);  expect_next(1, F_DN, 0);
        tick();

        // ch2: negative saturation, sticky flag, recovery, clear priority.
        for (int k = 1; k <= 300; k++) begin
            inc_m = 5'b00100;
            if (k == 255) begin
                expect_next(2, F_ERR, -255); expect_next(2, F_SAT, 0);
            end
            if (k == 256) begin
                expect_next(2, F_ERR, -255); expect_next(2, F_SAT, 1);
            end
            if (k == 300) begin
                expect_next(2, F_ERR, -255); expect_next(2, F_SAT, 1);
            end
            tick();
        end
        inc_p = 5'b00100;
        expect_next(2, F_ERR, -254); expect_next(2, F_SAT, 1);
        tick();
        clr = 5'b00100; inc_m = 5'b00100;
        expect_next(2, F_ERR, 0); expect_next(2, F_SAT, 0);
        tick();

        // ch3: cancelling commands with a drain sample, then a negative drain.
        drain[3] = 1'b1;
        inc_p = 5'b01000; inc_m = 5'b01000; ref_strobe = 1'b1;
        expect_next(3, F_ERR, 0); expect_next(3, F_PGP, 0); expect_next(3, F_PGM, 0);
        expect_next(3, F_UP, 0);  expect_next(3, F_DN, 0);
        tick();
        inc_m = 5'b01000;
        expect_next(3, F_ERR, -1);
        tick();
        ref_strobe = 1'b1;
        expect_next(3, F_ERR, 0); expect_next(3, F_PGM, 1);
        expect_next(3, F_DN, 1);  expect_next(3, F_UP, 0);
        tick();
        expect_next(3, F_PGM, 0); expect_next(3, F_DN, 1);
        tick();

        // ch4: err=5, pulse-gate inhibit blocks pulse and drain; ao drops levels.
        for (int k = 1; k <= 5; k++) begin
            inc_p = 5'b10000;
            tick();
        end
        del0 = 1'b1; drain[4] = 1'b1; ref_strobe = 1'b1;
        expect_next(4, F_UP, 1); expect_next(4, F_PGP, 0); expect_next(4, F_ERR, 5);
        tick();
        ao = 1'b0;
        expect_next(4, F_UP, 0); expect_next(0, F_UP, 0); expect_next(3, F_DN, 0);
        expect_next(4, F_ERR, 5);
        tick();
        ao = 1'b1; del0 = 1'b0;

        // Reset in the middle of draining, with the strobe high.
        ref_strobe = 1'b1;
        expect_next(4, F_ERR, 4); expect_next(4, F_PGP, 1);
        tick();
        rst = 1'b1; ref_strobe = 1'b1; inc_p = 5'b10000; clr = 5'b00001;
        expect_all_zero();
        tick();
        rst = 1'b0;
        for (int c = 0; c < CH; c++) begin
            expect_next(c, F_PGP, 0); expect_next(c, F_PGM, 0); expect_next(c, F_ERR, 0);
        end
        tick();

        tick();
        tick();
        #1;
        if (q.size() != 0) begin
            total++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/error_angle_array.md
ERROR_ANGLE_ARRAY -- requirements
Module: error_angle_array

Interface
REQ-001 Parameter CHANNELS, default 5, number of independent error-angle channels (1..8).
REQ-002 Parameter WIDTH, default 9, bits per signed error counter (4..16).
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous active-high reset, sampled on rising edge of clk.
REQ-005 ref_strobe  input  1  one-cycle pulse marking the reference-phase sampling instant, shared by all channels.
REQ-006 ao  input  1  analog-output enable; 0 forces all level outputs low.
REQ-007 del0  input  1  pulse-gate inhibit; 1 suppresses pg_p/pg_m and the drain step.
REQ-008 inc_p  input  CHANNELS  per-channel one-cycle +1 increment command.
REQ-009 inc_m  input  CHANNELS  per-channel one-cycle -1 decrement command.
REQ-010 clr  input  CHANNELS  per-channel synchronous clear of counter and sticky flag.
REQ-011 drain  input  CHANNELS  per-channel mode: 1 = closed-loop drain, 0 = open-loop hold.
REQ-012 up_lvl  output  CHANNELS  registered "error positive" level.
REQ-013 dn_lvl  output  CHANNELS  registered "error negative" level.
REQ-014 pg_p  output  CHANNELS  one-cycle plus pulse-gate output.
REQ-015 pg_m  output  CHANNELS  one-cycle minus pulse-gate output.
REQ-016 err  output  CHANNELS*WIDTH  packed two's-complement counters, channel i at bits [i*WIDTH +: WIDTH].
REQ-017 sat  output  CHANNELS  sticky saturation flag.

Function
REQ-018 Channels SHALL be fully independent except for shared ref_strobe, ao, del0, clk, rst.
REQ-019 Sample event S_t SHALL be ref_strobe=1 and ao=1 at edge t.
REQ-020 On S_t, up_lvl SHALL load (err>0) and dn_lvl SHALL load (err<0), using err before edge t; otherwise levels hold.
REQ-021 When ao=0 at an edge, up_lvl and dn_lvl SHALL both become 0 at that edge.
REQ-022 up_lvl and dn_lvl SHALL never be 1 simultaneously; err=0 on S_t yields both 0.
REQ-023 On S_t with del0=0, pg_p SHALL be 1 for exactly the following cycle iff err>0, pg_m iff err<0; in every other cycle both SHALL be 0.
REQ-024 Drain step d SHALL be -1 if err>0, +1 if err<0, 0 otherwise, applied only on S_t with del0=0 and drain=1; else d=0.
REQ-025 Net update per edge SHALL be err + inc_p - inc_m + d, computed in WIDTH+2 bits; inc_p and inc_m together cancel.
REQ-026 Counter SHALL saturate at +(2^(WIDTH-1)-1) and -(2^(WIDTH-1)-1); the most-negative code SHALL never be produced.
REQ-027 Any update clamped by REQ-026 SHALL set sat at the same edge; sat stays 1 until clr or rst.
REQ-028 clr SHALL have priority over inc_p, inc_m and drain: err=0, sat=0 at that edge; levels and pg outputs follow REQ-020/023 from the pre-edge err.
REQ-029 Latency: increment at edge t visible on err after edge t; reflected on up_lvl/dn_lvl at the first S after edge t.
REQ-030 ref_strobe asserted on consecutive cycles SHALL be treated as separate sample events.
REQ-031 Changing drain mid-operation SHALL take effect at the next edge with no other side effects.

Reset
REQ-032 While rst=1 at an edge, all err, sat, up_lvl, dn_lvl, pg_p, pg_m SHALL become 0, overriding every other input.
REQ-033 An S_t coincident with rst SHALL be discarded; no pg pulse SHALL appear in the cycle after reset release.
REQ-034 Reset SHALL restore all channels regardless of pending clr, increments or drain state.

Verification (CHANNELS=5, WIDTH=9)
REQ-035 ch0 3x inc_p, drain=0, then S -> err0=3, up_lvl0=1, dn_lvl0=0, pg_p0 one-cycle pulse, err0 stays 3.
REQ-036 ch1 err=2, drain=1, three S with del0=0 -> err1 2,1,0; pg_p1 pulses twice; after third S up_lvl1=dn_lvl1=0.
REQ-037 ch2 300x inc_m -> err2 saturates at -255 (0x101), sat2=1; one inc_p -> -254, sat2 still 1; clr -> err2=0, sat2=0.
REQ-038 ch3 inc_p and inc_m same cycle plus S with drain=1, err=0 -> err3=0, no pg pulses, levels 0.
REQ-039 ch4 err=5, del0=1, drain=1, S -> up_lvl4=1, no pg_p4, err4=5; then ao=0 -> up_lvl4=0 next cycle.
REQ-040 Mid-drain rst with ref_strobe high -> all outputs 0 after edge, no pg pulse the following cycle.
